// File: rtl/obi_data_req_buffer.sv
// OBI data-port request buffer: registers core requests in a small FIFO, caps
// in-flight transactions and passes in-order responses straight back.
package obi_data_req_buffer_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_data_req_buffer
  import obi_data_req_buffer_pkg::*;
#(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  obi_req_t         slv_req_i,
  output obi_resp_t        slv_resp_o,
  output obi_req_t         mst_req_o,
  input  obi_resp_t        mst_resp_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             idle_o,
  output logic             protocol_err_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } payload_t;

  payload_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic w_full, w_empty, w_push, w_pop, w_rsp_ok, w_rsp_bad;

  // Grant is built only from registered state so bus timing never reaches the core.
  assign w_full    = (r_occ == OCC_W'(DEPTH));
  assign w_empty   = (r_occ == '0);
  assign w_push    = slv_req_i.req && !w_full && (r_cnt < CNT_W'(MAX_OUTSTANDING));
  assign w_pop     = !w_empty && mst_resp_i.gnt;
  assign w_rsp_ok  = mst_resp_i.rvalid && (r_cnt != '0);
  assign w_rsp_bad = mst_resp_i.rvalid && (r_cnt == '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= '{addr: slv_req_i.addr, we: slv_req_i.we,
                                   be: slv_req_i.be, wdata: slv_req_i.wdata};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      case ({w_push, w_rsp_ok})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_rsp_bad) r_err <= 1'b1;
    end
  end

  always_comb begin
    mst_req_o = '0;
    if (!w_empty) begin
      mst_req_o.req   = 1'b1;
      mst_req_o.addr  = r_mem[r_rptr].addr;
      mst_req_o.we    = r_mem[r_rptr].we;
      mst_req_o.be    = r_mem[r_rptr].be;
      mst_req_o.wdata = r_mem[r_rptr].wdata;
    end
  end

  // Spurious responses (nothing outstanding) are dropped, only flagged.
  assign slv_resp_o.gnt    = w_push;
  assign slv_resp_o.rvalid = w_rsp_ok;
  assign slv_resp_o.rdata  = mst_resp_i.rdata;

  assign outstanding_o  = r_cnt;
  assign idle_o         = (r_cnt == '0);
  assign protocol_err_o = r_err;
endmodule

// File: tb/tb_obi_data_req_buffer.sv
// Directed bench for obi_data_req_buffer at DEPTH=2, MAX_OUTSTANDING=4.
module tb_obi_data_req_buffer;
  import obi_data_req_buffer_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_i = 1'b1;
  obi_req_t  slv_req_i;
  obi_resp_t slv_resp_o;
  obi_req_t  mst_req_o;
  obi_resp_t mst_resp_i;
  logic [2:0] outstanding_o;
  logic      idle_o, protocol_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  obi_data_req_buffer #(.DEPTH(2), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_req_i(slv_req_i), .slv_resp_o(slv_resp_o),
    .mst_req_o(mst_req_o), .mst_resp_i(mst_resp_i),
    .outstanding_o(outstanding_o), .idle_o(idle_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic core_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d);
    slv_req_i = '{req: 1'b1, addr: a, we: w, be: b, wdata: d};
  endtask

  initial begin
    int grants;
    slv_req_i  = '0;
    mst_resp_i = '0;

    // reset and idle
    repeat (2) tick();
    chk("rst_held_mreq", 32'(mst_req_o.req), 0);
    chk("rst_held_idle", 32'(idle_o), 1);
    rst_i = 1'b0;
    tick();
    chk("rst_mreq",  32'(mst_req_o.req), 0);
    chk("rst_maddr", mst_req_o.addr, 0);
    chk("rst_gnt",   32'(slv_resp_o.gnt), 0);
    chk("rst_out",   32'(outstanding_o), 0);
    chk("rst_idle",  32'(idle_o), 1);
    chk("rst_err",   32'(protocol_err_o), 0);

    // single write
    core_req(32'h1000_0000, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #1;
    chk("sw_gnt",    32'(slv_resp_o.gnt), 1);
    chk("sw_nobyp",  32'(mst_req_o.req), 0);
    tick();
    slv_req_i = '0;
    #1;
    chk("sw_mreq",   32'(mst_req_o.req), 1);
    chk("sw_maddr",  mst_req_o.addr, 32'h1000_0000);
    chk("sw_mwe",    32'(mst_req_o.we), 1);
    chk("sw_mbe",    32'(mst_req_o.be), 32'hF);
    chk("sw_mwdata", mst_req_o.wdata, 32'hDEAD_BEEF);
    chk("sw_out1",   32'(outstanding_o), 1);
    chk("sw_idle0",  32'(idle_o), 0);
    mst_resp_i.gnt = 1'b1;
    tick();
    mst_resp_i.gnt = 1'b0;
    #1;
    chk("sw_popped", 32'(mst_req_o.req), 0);
    chk("sw_pzero",  mst_req_o.wdata, 0);
    tick();
    mst_resp_i.rvalid = 1'b1;
    mst_resp_i.rdata  = 32'hCAFE_F00D;
    #1;
    chk("sw_rvalid", 32'(slv_resp_o.rvalid), 1);
    chk("sw_rdata",  slv_resp_o.rdata, 32'hCAFE_F00D);
    tick();
    mst_resp_i = '0;
    #1;
    chk("sw_out0",   32'(outstanding_o), 0);
    chk("sw_idle1",  32'(idle_o), 1);

    // backpressure: bus gnt held low, three requests
    core_req(32'hA, 1'b0, 4'h1, 32'h1);
    #1 chk("bp_gntA", 32'(slv_resp_o.gnt), 1);
    tick();
    core_req(32'hB, 1'b0, 4'h2, 32'h2);
    #1 chk("bp_gntB", 32'(slv_resp_o.gnt), 1);
    tick();
    core_req(32'hC, 1'b1, 4'h4, 32'h3);
    #1 chk("bp_gntC_full", 32'(slv_resp_o.gnt), 0);
    chk("bp_headA", mst_req_o.addr, 32'hA);
    tick();
    chk("bp_stableA", mst_req_o.addr, 32'hA);
    chk("bp_stablebe", 32'(mst_req_o.be), 32'h1);
    mst_resp_i.gnt = 1'b1;
    #1 chk("bp_gnt_popcycle", 32'(slv_resp_o.gnt), 0);
    tick();
    // occupancy 1: push C and pop B together
    #1 chk("bp_gntC", 32'(slv_resp_o.gnt), 1);
    chk("bp_headB", mst_req_o.addr, 32'hB);
    tick();
    slv_req_i = '0;
    #1 chk("sim_occ1_req", 32'(mst_req_o.req), 1);
    chk("sim_headC", mst_req_o.addr, 32'hC);
    chk("bp_out3", 32'(outstanding_o), 3);
    tick();
    mst_resp_i.gnt = 1'b0;
    #1 chk("bp_drained", 32'(mst_req_o.req), 0);
    mst_resp_i.rvalid = 1'b1;
    repeat (3) tick();
    mst_resp_i.rvalid = 1'b0;
    #1 chk("bp_out0", 32'(outstanding_o), 0);

    // outstanding cap
    mst_resp_i.gnt = 1'b1;
    grants = 0;
    for (int i = 0; i < 7; i++) begin
      core_req(32'h100 + 32'(i), 1'b0, 4'hF, 32'(i));
      #1 if (slv_resp_o.gnt) grants++;
      tick();
    end
    chk("cap_grants", 32'(grants), 4);
    chk("cap_out4",   32'(outstanding_o), 4);
    chk("cap_gnt0",   32'(slv_resp_o.gnt), 0);
    mst_resp_i.rvalid = 1'b1;
    #1 chk("cap_gnt_rv_cycle", 32'(slv_resp_o.gnt), 0);
    chk("cap_slv_rv", 32'(slv_resp_o.rvalid), 1);
    tick();
    mst_resp_i.rvalid = 1'b0;
    #1 chk("cap_out3",  32'(outstanding_o), 3);
    chk("cap_gnt_again", 32'(slv_resp_o.gnt), 1);
    tick();
    slv_req_i = '0;
    #1 chk("cap_out4b", 32'(outstanding_o), 4);
    tick();
    chk("cap_fifo_empty", 32'(mst_req_o.req), 0);

    // handshake and response in the same cycle
    mst_resp_i.rvalid = 1'b1;
    tick();
    core_req(32'h200, 1'b1, 4'h3, 32'h55);
    #1 chk("sim_gnt", 32'(slv_resp_o.gnt), 1);
    tick();
    slv_req_i = '0;
    mst_resp_i.rvalid = 1'b0;
    #1 chk("sim_out_unch", 32'(outstanding_o), 3);
    mst_resp_i.rvalid = 1'b1;
    repeat (3) tick();
    mst_resp_i.rvalid = 1'b0;
    #1 chk("sim_out0", 32'(outstanding_o), 0);

    // spurious response
    mst_resp_i.rvalid = 1'b1;
    mst_resp_i.rdata  = 32'h1234;
    #1 chk("sp_no_rvalid", 32'(slv_resp_o.rvalid), 0);
    tick();
    mst_resp_i = '0;
    #1 chk("sp_err", 32'(protocol_err_o), 1);
    chk("sp_out0", 32'(outstanding_o), 0);
    repeat (3) tick();
    chk("sp_sticky", 32'(protocol_err_o), 1);

    // reset mid-operation
    core_req(32'h300, 1'b1, 4'hF, 32'h77);
    tick();
    slv_req_i = '0;
    rst_i = 1'b1;
    #1 chk("mid_rst_req", 32'(mst_req_o.req), 0);
    chk("mid_rst_out", 32'(outstanding_o), 0);
    chk("mid_rst_err", 32'(protocol_err_o), 0);
    tick();
    rst_i = 1'b0;
    mst_resp_i.rvalid = 1'b1;
    tick();
    mst_resp_i = '0;
    #1 chk("post_rst_err", 32'(protocol_err_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/obi_data_req_buffer.md
Name: obi_data_req_buffer

Overview:
- Sits directly downstream of the CPU subsystem data port, between the core's OBI data master and the system bus.
- Registers and buffers core data requests in a DEPTH-entry FIFO, so bus grant timing never reaches the core's combinational grant path.
- Caps in-flight transactions at MAX_OUTSTANDING and forwards in-order OBI responses back to the core.
- Provides an idle indication for sleep/power control and a sticky protocol-error flag.

Parameters:
- DEPTH, 2, request FIFO entries; legal range >= 1; any value, not restricted to powers of two.
- MAX_OUTSTANDING, 4, maximum transactions accepted from the core and not yet answered; must be >= DEPTH.
- CNT_W, $clog2(MAX_OUTSTANDING+1), derived width of the outstanding counter; do not override.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- slv_req_i  in  obi_req_t  request from core data port (req, addr, we, be, wdata).
- slv_resp_o  out  obi_resp_t  gnt, rvalid, rdata back to core.
- mst_req_o  out  obi_req_t  request to bus.
- mst_resp_i  in  obi_resp_t  gnt, rvalid, rdata from bus.
- outstanding_o  out  CNT_W  current in-flight count.
- idle_o  out  1  high when outstanding_o == 0.
- protocol_err_o  out  1  sticky; set on unexpected bus rvalid.

Behaviour:
- Reset (asynchronous assert on rst_i high, state held while high):
  - FIFO empty, read/write pointers 0, counter 0, protocol_err_o 0.
  - mst_req_o all fields 0, slv_resp_o.gnt 0, outstanding_o 0, idle_o 1.
- Slave grant:
  - slv_resp_o.gnt = slv_req_i.req && !fifo_full && (cnt < MAX_OUTSTANDING).
  - Depends only on registered state and slv_req_i.req; never on mst_resp_i.
- Push: on slave handshake (req && gnt), {addr, we, be, wdata} is written at the write pointer and the write pointer advances.
- Full: when full, gnt = 0 even if the bus grants in the same cycle. No push-on-pop-when-full.
- Master request:
  - mst_req_o.req = !fifo_empty; mst_req_o.{addr, we, be, wdata} = FIFO head.
  - Fields are stable while req is high and gnt is low, as OBI requires.
  - When the FIFO is empty, all mst_req_o payload fields are 0.
- Pop: on master handshake (mst_req_o.req && mst_resp_i.gnt) the read pointer advances.
- Latency and ordering:
  - No bypass. A slave handshake in cycle N gives at earliest mst_req_o.req in cycle N+1.
  - With a continuously granting bus and DEPTH >= 2, throughput is 1 request per cycle.
  - Simultaneous push and pop with non-full, non-empty FIFO: both occur and occupancy is unchanged.
  - Push into an empty FIFO becomes visible the next cycle.
- Pointers wrap from DEPTH-1 to 0. Occupancy is tracked by a count register (0..DEPTH); full = count == DEPTH, empty = count == 0.
- Response path (combinational passthrough, zero latency):
  - slv_resp_o.rvalid = mst_resp_i.rvalid && (cnt != 0).
  - slv_resp_o.rdata = mst_resp_i.rdata.
  - OBI responses are in order; no reordering is done.
- Outstanding counter cnt:
  - +1 on slave handshake.
  - -1 on mst_resp_i.rvalid with cnt != 0.
  - Both in the same cycle: unchanged.
  - Counts accepted requests whether still buffered or issued to the bus.
  - Cannot exceed MAX_OUTSTANDING (grant gated) and never underflows.
- Protocol error:
  - mst_resp_i.rvalid while cnt == 0 sets protocol_err_o; the response is dropped (no slave rvalid) and cnt stays 0.
  - Clears only on reset.
- Reset mid-operation: buffered requests and in-flight accounting are discarded. Responses arriving after reset deassert with cnt == 0 set protocol_err_o.
- outstanding_o = cnt; idle_o = (cnt == 0), registered-state derived.

Test Plan:
- Reset then idle: rst_i pulse -> mst_req_o.req=0, slv gnt=0 with req low, outstanding_o=0, idle_o=1, protocol_err_o=0.
- Single write: core req addr=0x1000_0000, we=1, be=0xF, wdata=0xDEADBEEF -> gnt same cycle, mst_req_o.req next cycle with identical fields; bus gnt pops it; bus rvalid 2 cycles later -> slv rvalid same cycle, outstanding 1->0.
- Backpressure: DEPTH=2, bus gnt held 0, core issues 3 requests -> first 2 granted, 3rd gnt=0; mst fields stay stable; on bus gnt, the 3rd request is still not granted in that same cycle and is granted the next cycle.
- Outstanding cap: MAX_OUTSTANDING=4, bus always grants, rvalid withheld -> exactly 4 grants, outstanding_o=4, gnt=0 until one rvalid arrives, then one more grant.
- Simultaneous events: push and pop in the same cycle with occupancy 1 -> occupancy stays 1; slave handshake and bus rvalid in the same cycle -> outstanding unchanged.
- Spurious response: bus rvalid with outstanding_o=0, rdata=0x1234 -> no slv rvalid, protocol_err_o=1 and stays set until rst_i.
